// File: rtl/calc_alu_sequencer.sv
// calc_alu_sequencer: keypad front-end for the calculator ALU.
// Builds decimal operands A and B and an operator from keypad strobes, launches one
// ALU operation, waits for alu_valid (with timeout), then latches and shows the result.
// Optional build macro: DIV_ZERO_CHECK_EN traps divide-by-zero before issue.
module calc_alu_sequencer #(
  parameter int inSize  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  digit_valid,
  input  logic [3:0]            digit,
  input  logic                  op_valid,
  input  logic [1:0]            op,
  input  logic                  eq_valid,
  input  logic                  clr,
  output logic                  alu_en,
  output logic [1:0]            alu_op,
  output logic [inSize-1:0]     alu_A,
  output logic [inSize-1:0]     alu_B,
  input  logic [2*inSize-1:0]   alu_result,
  input  logic                  alu_valid,
  output logic [2*inSize-1:0]   disp,
  output logic                  res_valid,
  output logic                  busy,
  output logic                  err
);

`ifdef DIV_ZERO_CHECK_EN
  localparam bit DivZeroCheck = 1'b1;
`else
  localparam bit DivZeroCheck = 1'b0;
`endif

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_ENTER_A,
    S_ENTER_B,
    S_ISSUE,
    S_WAIT,
    S_SHOW,
    S_ERR
  } state_t;

  state_t               state, n_state;
  logic [inSize-1:0]    a, b, n_a, n_b;
  logic [1:0]           opr, n_op;
  logic [2*inSize-1:0]  result, n_result;
  logic [CW-1:0]        cnt, n_cnt;
  logic                 n_rv;
  logic                 digit_ok;

  // Append a decimal digit; an entry that would overflow the operand is dropped.
  function automatic logic [inSize-1:0] push_digit(input logic [inSize-1:0] cur,
                                                   input logic [3:0] d);
    logic [inSize+3:0] v;
    v = {4'b0, cur} * (inSize+4)'(10) + {{inSize{1'b0}}, d};
    if (v > {4'b0, {inSize{1'b1}}}) return cur;
    return v[inSize-1:0];
  endfunction

  assign digit_ok = digit_valid && (digit <= 4'd9);

  // Next-state logic; event priority clr > eq > op > digit, losers dropped.
  always_comb begin
    n_state  = state;
    n_a      = a;
    n_b      = b;
    n_op     = opr;
    n_result = result;
    n_cnt    = cnt;
    n_rv     = 1'b0;
    if (clr) begin
      n_state  = S_ENTER_A;
      n_a      = '0;
      n_b      = '0;
      n_op     = '0;
      n_result = '0;
      n_cnt    = '0;
    end else begin
      case (state)
        S_ENTER_A: begin
          if (eq_valid) begin
            n_state = state;
          end else if (op_valid) begin
            n_op    = op;
            n_b     = '0;
            n_state = S_ENTER_B;
          end else if (digit_ok) begin
            n_a = push_digit(a, digit);
          end
        end
        S_ENTER_B: begin
          if (eq_valid) begin
            if (DivZeroCheck && opr == 2'b11 && b == '0) n_state = S_ERR;
            else                                        n_state = S_ISSUE;
          end else if (op_valid) begin
            n_op = op;
          end else if (digit_ok) begin
            n_b = push_digit(b, digit);
          end
        end
        S_ISSUE: begin
          n_state = S_WAIT;
          n_cnt   = '0;
        end
        S_WAIT: begin
          if (alu_valid) begin
            n_result = alu_result;
            n_rv     = 1'b1;
            n_state  = S_SHOW;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            n_state = S_ERR;
          end else begin
            n_cnt = cnt + 1'b1;
          end
        end
        S_SHOW: begin
          if (eq_valid) begin
            n_state = S_ISSUE;
          end else if (op_valid) begin
            if (result[2*inSize-1:inSize] != '0) begin
              n_state = S_ERR;
            end else begin
              n_a     = result[inSize-1:0];
              n_op    = op;
              n_b     = '0;
              n_state = S_ENTER_B;
            end
          end else if (digit_ok) begin
            n_a     = push_digit('0, digit);
            n_state = S_ENTER_A;
          end
        end
        S_ERR:   n_state = S_ERR;
        default: n_state = S_ENTER_A;
      endcase
    end
  end

  // State/operand registers; outputs are registered from the next-state values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_ENTER_A;
      a         <= '0;
      b         <= '0;
      opr       <= '0;
      result    <= '0;
      cnt       <= '0;
      disp      <= '0;
      alu_en    <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= n_state;
      a         <= n_a;
      b         <= n_b;
      opr       <= n_op;
      result    <= n_result;
      cnt       <= n_cnt;
      alu_en    <= (n_state == S_ISSUE);
      res_valid <= n_rv;
      busy      <= (n_state == S_ISSUE) || (n_state == S_WAIT);
      err       <= (n_state == S_ERR);
      case (n_state)
        S_ENTER_A: disp <= {{inSize{1'b0}}, n_a};
        S_ENTER_B: disp <= {{inSize{1'b0}}, n_b};
        S_SHOW:    disp <= n_result;
        S_ERR:     disp <= '0;
        default:   disp <= disp;
      endcase
    end
  end

  assign alu_A  = a;
  assign alu_B  = b;
  assign alu_op = opr;

endmodule

// File: tb/tb_calc_alu_sequencer.sv
// Scoreboard bench for calc_alu_sequencer (inSize=4, TIMEOUT=15) with a
// 2-cycle-latency ALU model that can be silenced.
module tb_calc_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       digit_valid = 1'b0;
  logic [3:0] digit = '0;
  logic       op_valid = 1'b0;
  logic [1:0] op = '0;
  logic       eq_valid = 1'b0;
  logic       clr = 1'b0;
  logic       alu_en;
  logic [1:0] alu_op;
  logic [3:0] alu_A, alu_B;
  logic [7:0] alu_result;
  logic       alu_valid;
  logic [7:0] disp;
  logic       res_valid, busy, err;

  calc_alu_sequencer #(.inSize(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .digit_valid(digit_valid), .digit(digit),
    .op_valid(op_valid), .op(op), .eq_valid(eq_valid), .clr(clr),
    .alu_en(alu_en), .alu_op(alu_op), .alu_A(alu_A), .alu_B(alu_B),
    .alu_result(alu_result), .alu_valid(alu_valid), .disp(disp),
    .res_valid(res_valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // ALU model: answers 2 cycles after alu_en unless silenced.
  logic alu_live = 1'b1;
  logic v1 = 1'b0, v2 = 1'b0;
  always @(posedge clk) begin
    v1 <= alu_en & alu_live;
    v2 <= v1;
  end
  assign alu_valid = v2;
  always_comb begin
    case (alu_op)
      2'b00:   alu_result = {4'b0, alu_A} + {4'b0, alu_B};
      2'b01:   alu_result = {4'b0, alu_A} - {4'b0, alu_B};
      2'b10:   alu_result = {4'b0, alu_A} * {4'b0, alu_B};
      default: alu_result = (alu_B == 4'd0) ? 8'hFF : {4'b0, alu_A / alu_B};
    endcase
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
  } launch_t;

  launch_t    lq[$];
  logic [7:0] rq[$];
  int en_count  = 0;
  int res_count = 0;

  // Monitor: pop expectations when the DUT launches or produces a result.
  always @(posedge clk) begin
    #1;
    if (alu_en) begin
      en_count++;
      if (lq.size() == 0) check("unexpected_alu_en", 1, 0);
      else begin
        launch_t e;
        e = lq.pop_front();
        check("alu_A", {28'b0, alu_A}, {28'b0, e.a});
        check("alu_B", {28'b0, alu_B}, {28'b0, e.b});
        check("alu_op", {30'b0, alu_op}, {30'b0, e.op});
      end
    end
    if (res_valid) begin
      res_count++;
      if (rq.size() == 0) check("unexpected_res_valid", 1, 0);
      else check("result_disp", {24'b0, disp}, {24'b0, rq.pop_front()});
    end
  end

  task automatic press_digit(input logic [3:0] d);
    @(negedge clk); digit_valid = 1'b1; digit = d;
    @(negedge clk); digit_valid = 1'b0;
  endtask

  task automatic press_op(input logic [1:0] o);
    @(negedge clk); op_valid = 1'b1; op = o;
    @(negedge clk); op_valid = 1'b0;
  endtask

  task automatic press_eq();
    @(negedge clk); eq_valid = 1'b1;
    @(negedge clk); eq_valid = 1'b0;
  endtask

  task automatic press_clr();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic expect_op(input logic [3:0] a, input logic [3:0] b,
                           input logic [1:0] o, input logic [7:0] r, input bit want_res);
    launch_t e;
    e.a = a; e.b = b; e.op = o;
    lq.push_back(e);
    if (want_res) rq.push_back(r);
  endtask

  task automatic wait_res(input string tag);
    int start;
    bit seen;
    start = res_count;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (res_count != start) seen = 1'b1;
    end
    if (!seen) check(tag, 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int en0, rs0;
    // Reset state
    repeat (2) @(negedge clk);
    check("reset_outputs", {15'b0, alu_en, res_valid, busy, err, disp, alu_op, alu_A},
          32'd0);
    check("reset_alu_B", {28'b0, alu_B}, 0);
    rst = 1'b0;

    // 1) 12 + 3
    press_digit(4'd1);
    press_digit(4'd2);
    check("t1_dispA", {24'b0, disp}, 12);
    press_op(2'b00);
    check("t1_dispB0", {24'b0, disp}, 0);
    press_digit(4'd3);
    check("t1_dispB", {24'b0, disp}, 3);
    expect_op(4'd12, 4'd3, 2'b00, 8'd15, 1'b1);
    press_eq();
    check("t1_busy_issue", {31'b0, busy}, 1);
    wait_res("t1_res_timeout");
    @(negedge clk);
    check("t1_disp", {24'b0, disp}, 15);
    check("t1_idle", {30'b0, busy, err}, 0);
    check("t1_en_count", en_count, 1);

    // 2) chain 15 * 2 = 30, then chaining with upper bits set errors
    press_op(2'b10);
    check("t2_chain_dispB", {24'b0, disp}, 0);
    press_digit(4'd2);
    expect_op(4'd15, 4'd2, 2'b10, 8'd30, 1'b1);
    press_eq();
    wait_res("t2_res_timeout");
    @(negedge clk);
    check("t2_disp", {24'b0, disp}, 30);
    press_op(2'b00);
    check("t2_err", {31'b0, err}, 1);
    check("t2_err_disp", {24'b0, disp}, 0);
    press_clr();
    check("t2_clr", {23'b0, err, disp}, 0);

    // 3) overflow digit ignored; same-cycle digit+op takes op only
    press_digit(4'd1);
    press_digit(4'd2);
    press_digit(4'd3);
    check("t3_overflow", {24'b0, disp}, 12);
    @(negedge clk); digit_valid = 1'b1; digit = 4'd5; op_valid = 1'b1; op = 2'b01;
    @(negedge clk); digit_valid = 1'b0; op_valid = 1'b0;
    check("t3_prio_dispB", {24'b0, disp}, 0);
    press_digit(4'd4);
    expect_op(4'd12, 4'd4, 2'b01, 8'd8, 1'b1);
    press_eq();
    wait_res("t3_res_timeout");
    @(negedge clk);
    check("t3_disp", {24'b0, disp}, 8);

    // 4) silent ALU -> timeout after 15 WAIT cycles
    press_clr();
    press_digit(4'd5);
    press_op(2'b00);
    press_digit(4'd1);
    alu_live = 1'b0;
    expect_op(4'd5, 4'd1, 2'b00, 8'd0, 1'b0);
    press_eq();
    repeat (15) @(negedge clk);
    check("t4_no_err_early", {30'b0, err, busy}, 1);
    @(negedge clk);
    check("t4_err_timeout", {30'b0, err, busy}, 2);
    press_clr();
    check("t4_clr", {23'b0, err, disp}, 0);
    alu_live = 1'b1;

    // 5) divide by zero
    en0 = en_count;
    press_digit(4'd7);
    press_op(2'b11);
`ifdef DIV_ZERO_CHECK_EN
    press_eq();
    check("t5_div0_err", {31'b0, err}, 1);
    repeat (5) @(negedge clk);
    check("t5_no_en", en_count - en0, 0);
`else
    expect_op(4'd7, 4'd0, 2'b11, 8'hFF, 1'b1);
    press_eq();
    wait_res("t5_res_timeout");
    @(negedge clk);
    check("t5_div_disp", {24'b0, disp}, 255);
    check("t5_one_en", en_count - en0, 1);
`endif
    press_clr();

    // 6) async reset while waiting; late alu_valid must be ignored
    press_digit(4'd2);
    press_op(2'b10);
    press_digit(4'd3);
    expect_op(4'd2, 4'd3, 2'b10, 8'd0, 1'b0);
    press_eq();
    @(negedge clk);
    en0 = en_count;
    rs0 = res_count;
    #2 rst = 1'b1;
    #1;
    check("t6_async_rst", {15'b0, alu_en, res_valid, busy, err, disp, alu_op, alu_A},
          32'd0);
    check("t6_rst_alu_B", {28'b0, alu_B}, 0);
    @(negedge clk); rst = 1'b0;
    repeat (6) @(negedge clk);
    check("t6_no_res_valid", res_count - rs0, 0);
    check("t6_no_en", en_count - en0, 0);
    check("t6_idle", {22'b0, busy, err, disp}, 0);

    check("launch_q_empty", lq.size(), 0);
    check("result_q_empty", rq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
